icache_fill_ctrl: RTL
=====================

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDRW, 32, byte address width.
  LINEW, 512, cache line width in bits (64 bytes).
  INSTRW, 16, instruction width in bits.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  pc_valid  in  1  core is requesting the instruction at pc.
  pc  in  ADDRW  fetch byte address; bit 0 is ignored.
  flush  in  1  invalidates the resident line.
  stall  out  1  core shall hold pc while high.
  mem_req  out  1  line read request to memory.
  mem_addr  out  ADDRW  line-aligned request address; low 6 bits are 0.
  mem_ack  in  1  mem_data valid this cycle; completes the request.
  mem_data  in  LINEW  returned line, first instruction in the MSBs.
  cache_write  out  1  write strobe to the single-line instruction cache.
  cache_line  out  LINEW  line data to the cache.
  cache_base  out  ADDRW  line base address to the cache.
  cache_addr  out  ADDRW  read address to the cache; equals pc.
  miss_count  out  16  saturating count of misses.
REQ-003 The block SHALL use one clock, clk; rst_n SHALL be synchronous and active-low.

Function
REQ-004 The block SHALL hold line_valid (1 bit) and line_base (ADDRW) registers that track the line resident in the cache.
REQ-005 hit SHALL be line_valid AND pc_valid AND (pc[ADDRW-1:6] == line_base[ADDRW-1:6]).
REQ-006 The FSM states SHALL be IDLE, MISS, FILL, RESUME.
REQ-007 IDLE, pc_valid=1 and hit=0: latch mem_addr = {pc[ADDRW-1:6], 6'b0}, increment miss_count, go to MISS.
REQ-008 IDLE, pc_valid=0 or hit=1: stay in IDLE.
REQ-009 MISS: mem_req=1 with mem_addr held stable; on mem_ack=1, capture mem_data into cache_line, set line_base=mem_addr, go to FILL.
REQ-010 mem_req SHALL be registered and SHALL be high in every MISS cycle only.
REQ-011 FILL: cache_write=1 for exactly one cycle, line_valid<=1, go to RESUME.
REQ-012 RESUME: one cycle that covers the cache's registered read latency, then go to IDLE.
REQ-013 stall SHALL be (state != IDLE) OR (pc_valid AND NOT hit); it SHALL be combinational in IDLE.
REQ-014 Minimum miss penalty: 3 cycles plus memory latency, counted from the miss cycle to the first non-stalled cycle after a single-cycle ack.
REQ-015 cache_base SHALL equal line_base at all times; cache_addr SHALL equal pc.
REQ-016 mem_ack outside MISS SHALL be ignored.
REQ-017 pc changes while state != IDLE SHALL be ignored; hit SHALL be re-evaluated in IDLE.
REQ-018 flush in IDLE SHALL clear line_valid on the next edge.
REQ-019 flush outside IDLE SHALL set flush_pend; the in-flight fill SHALL complete; on entry to IDLE, line_valid and flush_pend SHALL be cleared.
REQ-020 flush in the same IDLE cycle as a miss: the miss SHALL proceed, and the resulting line SHALL be valid.
REQ-021 miss_count SHALL saturate at 16'hFFFF.

Reset
REQ-022 With rst_n=0 at an edge, the block SHALL set:
  state=IDLE, line_valid=0, line_base=0, flush_pend=0.
  mem_req=0, mem_addr=0, cache_write=0, cache_line=0, miss_count=0.
REQ-023 Reset mid-MISS or mid-FILL SHALL abandon the transaction; a late mem_ack afterwards SHALL be ignored.
REQ-024 stall SHALL equal pc_valid during and after reset until the first fill.

Verification
REQ-025 Cold miss: reset, pc=0x1000, pc_valid=1 -> mem_req and mem_addr=0x1000 next cycle; ack after 5 cycles -> cache_write one cycle, stall low 2 cycles later, miss_count=1.
REQ-026 Hit window: after a fill at 0x1000, pc=0x103E -> stall=0; pc=0x1040 -> stall=1 and mem_addr=0x1040, miss_count=2.
REQ-027 Flush: flush during MISS for 0x2000 -> fill completes, line_valid=0 in IDLE, pc=0x2000 refetches, miss_count increments.
REQ-028 Reset mid-MISS: rst_n=0 with mem_req=1, then mem_ack=1 one cycle after reset -> no cache_write, mem_req=0.
REQ-029 Saturation: preload miss_count to 0xFFFE, force 3 misses -> count reads 0xFFFF.
REQ-030 Spurious ack: mem_ack=1 in IDLE with pc hit -> no state change, cache_line unchanged.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// Fill controller for a single-line instruction cache: detects fetch misses,
// reads the missing 64-byte line from memory and writes it into the cache.
module icache_fill_ctrl #(
   parameter int unsigned ADDRW  = 32,
   parameter int unsigned LINEW  = 512,
   parameter int unsigned INSTRW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pc_valid,
   input  logic [ADDRW-1:0] pc,
   input  logic             flush,
   output logic             stall,
   output logic             mem_req,
   output logic [ADDRW-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [LINEW-1:0] mem_data,
   output logic             cache_write,
   output logic [LINEW-1:0] cache_line,
   output logic [ADDRW-1:0] cache_base,
   output logic [ADDRW-1:0] cache_addr,
   output logic [15:0]      miss_count
);

   localparam int unsigned OFFW = 6;
   localparam int unsigned CNTW = 16;

   // Line must be 64 bytes and hold a whole number of instructions.
   if (((LINEW % INSTRW) != 0) || ((LINEW / 8) != (1 << OFFW))) begin : g_param_check
      $error("icache_fill_ctrl: LINEW must be 512 and a multiple of INSTRW");
   end

   typedef enum logic [1:0] {IDLE, MISS, FILL, RESUME} state_t;

   state_t           state_q, state_d;
   logic             line_valid_q, line_valid_d;
   logic [ADDRW-1:0] line_base_q, line_base_d;
   logic             flush_pend_q, flush_pend_d;
   logic             mem_req_d;
   logic [ADDRW-1:0] mem_addr_d;
   logic             cache_write_d;
   logic [LINEW-1:0] cache_line_d;
   logic [CNTW-1:0]  miss_count_d;
   logic             hit_c;

   assign hit_c = line_valid_q && pc_valid &&
                  (pc[ADDRW-1:OFFW] == line_base_q[ADDRW-1:OFFW]);

   // Reset forces the cold-cache view so the core sees stall == pc_valid.
   assign stall = !rst_n ? pc_valid
                         : ((state_q != IDLE) || (pc_valid && !hit_c));

   assign cache_base = line_base_q;
   assign cache_addr = pc;

   // Next-state and next-register values.
   always_comb begin
      state_d       = state_q;
      line_valid_d  = line_valid_q;
      line_base_d   = line_base_q;
      flush_pend_d  = flush_pend_q;
      mem_req_d     = 1'b0;
      mem_addr_d    = mem_addr;
      cache_write_d = 1'b0;
      cache_line_d  = cache_line;
      miss_count_d  = miss_count;
      case (state_q)
         IDLE: begin
            if (flush) line_valid_d = 1'b0;
            if (pc_valid && !hit_c) begin
               state_d    = MISS;
               mem_req_d  = 1'b1;
               mem_addr_d = {pc[ADDRW-1:OFFW], OFFW'(0)};
               if (miss_count != {CNTW{1'b1}}) miss_count_d = miss_count + CNTW'(1);
            end
         end
         MISS: begin
            if (flush) flush_pend_d = 1'b1;
            if (mem_ack) begin
               state_d       = FILL;
               cache_line_d  = mem_data;
               line_base_d   = mem_addr;
               cache_write_d = 1'b1;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         FILL: begin
            if (flush) flush_pend_d = 1'b1;
            line_valid_d = 1'b1;
            state_d      = RESUME;
         end
         RESUME: begin
            // A flush seen during the fill drops the new line on return to IDLE.
            if (flush_pend_q || flush) line_valid_d = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         line_valid_q <= 1'b0;
         line_base_q  <= '0;
         flush_pend_q <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         cache_write  <= 1'b0;
         cache_line   <= '0;
         miss_count   <= '0;
      end else begin
         state_q      <= state_d;
         line_valid_q <= line_valid_d;
         line_base_q  <= line_base_d;
         flush_pend_q <= flush_pend_d;
         mem_req      <= mem_req_d;
         mem_addr     <= mem_addr_d;
         cache_write  <= cache_write_d;
         cache_line   <= cache_line_d;
         miss_count   <= miss_count_d;
      end
   end

endmodule
